// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, state and size encodings for the memory controller
package mem_ctrl_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  function automatic logic size_ok(input logic [2:0] s);
    return s == SIZE_B || s == SIZE_H || s == SIZE_W;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetcher, LSB, RAM and ROB signals seen by the memory controller
interface mem_ctrl_if import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) ();
  logic              in_fetcher_ce;
  logic [ADDR_W-1:0] in_fetcher_pc;
  logic              out_fetcher_ce;
  logic [DATA_W-1:0] out_fetcher_instr;
  logic              in_lsb_ce;
  logic              in_lsb_wr;
  logic [ADDR_W-1:0] in_lsb_addr;
  logic [2:0]        in_lsb_size;
  logic [DATA_W-1:0] in_lsb_data;
  logic              out_lsb_ce;
  logic [DATA_W-1:0] out_lsb_data;
  logic [7:0]        in_ram_data;
  logic [7:0]        out_ram_data;
  logic [ADDR_W-1:0] out_ram_addr;
  logic              out_ram_wr;
  logic              in_rob_misbranch;
  modport slave (
    input  in_fetcher_ce, in_fetcher_pc, in_lsb_ce, in_lsb_wr, in_lsb_addr, in_lsb_size,
           in_lsb_data, in_ram_data, in_rob_misbranch,
    output out_fetcher_ce, out_fetcher_instr, out_lsb_ce, out_lsb_data,
           out_ram_data, out_ram_addr, out_ram_wr
  );
  modport master (
    output in_fetcher_ce, in_fetcher_pc, in_lsb_ce, in_lsb_wr, in_lsb_addr, in_lsb_size,
           in_lsb_data, in_ram_data, in_rob_misbranch,
    input  out_fetcher_ce, out_fetcher_instr, out_lsb_ce, out_lsb_data,
           out_ram_data, out_ram_addr, out_ram_wr
  );
endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// mem_byte_seq: issues one RAM byte cycle per edge and strobes each read byte two edges later
module mem_byte_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        len,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wr,
  output logic              cap,
  output logic [1:0]        cap_idx,
  output logic              done
);
  logic active, wr_q, last, p_v, cap_l;
  logic [2:0] idx, len_q;
  logic [1:0] p_i;
  logic [DATA_W-1:0] wd;
  assign done = (ram_wr & last) | (cap & cap_l);
  // address/write issue plus a two-stage tag pipeline matching the RAM read latency
  always_ff @(posedge clk)
    if (rst) begin
      active <= 1'b0;
      wr_q <= 1'b0;
      last <= 1'b0;
      p_v <= 1'b0;
      p_i <= '0;
      cap <= 1'b0;
      cap_l <= 1'b0;
      cap_idx <= '0;
      idx <= '0;
      len_q <= '0;
      wd <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wr <= 1'b0;
    end else if (en) begin
      cap <= p_v & ~abort;
      cap_idx <= p_i;
      cap_l <= last;
      if (abort) begin
        active <= 1'b0;
        ram_wr <= 1'b0;
        p_v <= 1'b0;
      end else if (start) begin
        active <= len > 3'd1;
        idx <= 3'd1;
        len_q <= len;
        wr_q <= wr;
        wd <= wdata;
        ram_addr <= base;
        ram_data <= wdata[7:0];
        ram_wr <= wr;
        last <= len == 3'd1;
        p_v <= ~wr;
        p_i <= 2'd0;
      end else if (active) begin
        active <= idx + 3'd1 < len_q;
        idx <= idx + 3'd1;
        ram_addr <= ram_addr + 1'b1;
        ram_data <= wd[{idx[1:0], 3'b000} +: 8];
        ram_wr <= wr_q;
        last <= idx + 3'd1 == len_q;
        p_v <= ~wr_q;
        p_i <= idx[1:0];
      end else begin
        ram_wr <= 1'b0;
        p_v <= 1'b0;
      end
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and LSB requests onto the byte-wide RAM port and flushes on misbranch
module mem_ctrl import mem_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  mem_ctrl_if.slave bus
);
  state_t state;
  logic pf, pl, pl_wr, go, go_l, l_any, f_any, l_wr, abort, cap, done;
  logic [ADDR_W-1:0] pf_pc, pl_addr, l_addr, f_pc, s_base;
  logic [2:0] pl_size, l_size, s_len;
  logic [DATA_W-1:0] pl_data, l_data, acc, word;
  logic [1:0] cap_idx;
  // a request pulse is served in the same edge it arrives, so look through the pending slots
  always_comb begin
    l_any = pl | bus.in_lsb_ce;
    f_any = pf | bus.in_fetcher_ce;
    l_wr = bus.in_lsb_ce ? bus.in_lsb_wr : pl_wr;
    l_addr = bus.in_lsb_ce ? bus.in_lsb_addr : pl_addr;
    l_size = bus.in_lsb_ce ? bus.in_lsb_size : pl_size;
    l_data = bus.in_lsb_ce ? bus.in_lsb_data : pl_data;
    f_pc = bus.in_fetcher_ce ? bus.in_fetcher_pc : pf_pc;
    go = state == IDLE && !bus.in_rob_misbranch && (l_any || f_any);
    go_l = go && l_any;
    s_base = go_l ? l_addr : f_pc;
    s_len = go_l ? l_size : SIZE_W;
    abort = bus.in_rob_misbranch && (state == FETCH || state == LOAD);
    word = acc;
    word[{cap_idx, 3'b000} +: 8] = bus.in_ram_data;
  end
  mem_byte_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_seq (
    .clk(clk),
    .rst(rst),
    .en(rdy),
    .start(go),
    .abort(abort),
    .base(s_base),
    .len(s_len),
    .wr(go_l & l_wr),
    .wdata(l_data),
    .ram_addr(bus.out_ram_addr),
    .ram_data(bus.out_ram_data),
    .ram_wr(bus.out_ram_wr),
    .cap(cap),
    .cap_idx(cap_idx),
    .done(done)
  );
  // pending slots, arbitration FSM and acks; misbranch overrides everything except stores
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      pf <= FALSE;
      pl <= FALSE;
      pl_wr <= FALSE;
      pf_pc <= '0;
      pl_addr <= '0;
      pl_size <= '0;
      pl_data <= '0;
      acc <= '0;
      bus.out_fetcher_ce <= FALSE;
      bus.out_fetcher_instr <= '0;
      bus.out_lsb_ce <= FALSE;
      bus.out_lsb_data <= '0;
    end else if (rdy) begin
      bus.out_fetcher_ce <= FALSE;
      bus.out_lsb_ce <= FALSE;
      if (cap) acc[{cap_idx, 3'b000} +: 8] <= bus.in_ram_data;
      if (bus.in_fetcher_ce) begin
        pf <= TRUE;
        pf_pc <= bus.in_fetcher_pc;
      end
      if (bus.in_lsb_ce) begin
        pl <= TRUE;
        pl_wr <= bus.in_lsb_wr;
        pl_addr <= bus.in_lsb_addr;
        pl_size <= bus.in_lsb_size;
        pl_data <= bus.in_lsb_data;
      end
      case (state)
        IDLE: if (go) begin
          acc <= '0;
          state <= !go_l ? FETCH : l_wr ? STORE : LOAD;
          if (go_l) pl <= FALSE;
          else pf <= FALSE;
        end
        FETCH: if (done) begin
          bus.out_fetcher_ce <= TRUE;
          bus.out_fetcher_instr <= word;
          state <= IDLE;
        end
        LOAD: if (done) begin
          bus.out_lsb_ce <= TRUE;
          bus.out_lsb_data <= word;
          state <= IDLE;
        end
        default: if (done) begin
          bus.out_lsb_ce <= TRUE;
          state <= IDLE;
        end
      endcase
      if (bus.in_rob_misbranch) begin
        pf <= bus.in_fetcher_ce;
        if (!l_wr) pl <= FALSE;
        if (abort) begin
          state <= IDLE;
          bus.out_fetcher_ce <= FALSE;
          bus.out_lsb_ce <= FALSE;
        end
      end
    end
  a_size: assert property (@(posedge clk) disable iff (rst) bus.in_lsb_ce |-> size_ok(bus.in_lsb_size))
    else $error("illegal in_lsb_size %0d", bus.in_lsb_size);
  a_data_w: assert property (@(posedge clk) DATA_W == DATA_WIDTH && ZERO_DATA == '0);
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of fetch, load/store, arbitration, misbranch, rdy and reset
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, rdy;
  int n_chk = 0;
  int n_fail = 0;
  mem_ctrl_if bus ();
  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] mem [0:1023];
  logic [7:0] ram_q;
  logic pk;
  logic [9:0] pk_a;
  logic [7:0] pk_d;
  assign bus.in_ram_data = ram_q;
  // byte RAM with registered read, gated by rdy; pk is a bench-side preload port
  always @(posedge clk)
    if (pk) mem[pk_a] <= pk_d;
    else if (rdy) begin
      ram_q <= mem[bus.out_ram_addr[9:0]];
      if (bus.out_ram_wr) mem[bus.out_ram_addr[9:0]] <= bus.out_ram_data;
    end
  task automatic poke4(input logic [9:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      pk = 1'b1;
      pk_a = a + 10'(i);
      pk_d = w[8*i +: 8];
      @(posedge clk); #1;
    end
    pk = 1'b0;
  endtask
  task automatic req_fetch(input logic [31:0] pc);
    bus.in_fetcher_ce = 1'b1;
    bus.in_fetcher_pc = pc;
    @(posedge clk); #1;
    bus.in_fetcher_ce = 1'b0;
  endtask
  task automatic req_lsb(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    bus.in_lsb_ce = 1'b1;
    bus.in_lsb_wr = wr;
    bus.in_lsb_addr = a;
    bus.in_lsb_size = sz;
    bus.in_lsb_data = d;
    @(posedge clk); #1;
    bus.in_lsb_ce = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rdy = 1'b1;
    pk = 1'b0;
    bus.in_fetcher_ce = 1'b0;
    bus.in_fetcher_pc = '0;
    bus.in_lsb_ce = 1'b0;
    bus.in_lsb_wr = 1'b0;
    bus.in_lsb_addr = '0;
    bus.in_lsb_size = SIZE_W;
    bus.in_lsb_data = '0;
    bus.in_rob_misbranch = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.out_fetcher_ce, bus.out_fetcher_instr, bus.out_lsb_ce, bus.out_lsb_data,
         bus.out_ram_data, bus.out_ram_addr, bus.out_ram_wr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fce=%b instr=%h lce=%b ldata=%h rdata=%h raddr=%h rwr=%b, need all 0",
               bus.out_fetcher_ce, bus.out_fetcher_instr, bus.out_lsb_ce, bus.out_lsb_data,
               bus.out_ram_data, bus.out_ram_addr, bus.out_ram_wr);
    end
    rst = 1'b0;
  endtask
  task automatic test_fetch;
    poke4(10'h004, 32'h00100513);
    req_fetch(32'h4);
    n_chk++;
    if (bus.out_ram_addr !== 32'h4 || bus.out_ram_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_addr0: got addr=%h wr=%b, need 4 0", bus.out_ram_addr, bus.out_ram_wr);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k < 4) begin
        n_chk++;
        if (bus.out_ram_addr !== 32'(4 + k)) begin
          n_fail++;
          $display("FAIL fetch_addr%0d: got %h, need %h", k, bus.out_ram_addr, 4 + k);
        end
      end
      n_chk++;
      if (bus.out_fetcher_ce !== (k == 5)) begin
        n_fail++;
        $display("FAIL fetch_ack_cycle%0d: got %b, need %b", k, bus.out_fetcher_ce, k == 5);
      end
    end
    n_chk++;
    if (bus.out_fetcher_instr !== 32'h00100513) begin
      n_fail++;
      $display("FAIL fetch_instr: got %h, need 00100513", bus.out_fetcher_instr);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.out_fetcher_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ack_width: got %b, need 0", bus.out_fetcher_ce);
    end
  endtask
  task automatic test_store;
    poke4(10'h100, 32'h0055_0000);
    req_lsb(1'b1, 32'h100, SIZE_H, 32'hDEADBEEF);
    n_chk++;
    if ({bus.out_ram_addr, bus.out_ram_wr, bus.out_ram_data} !== {32'h100, 1'b1, 8'hEF}) begin
      n_fail++;
      $display("FAIL store_w0: got %h %b %h, need 100 1 ef", bus.out_ram_addr, bus.out_ram_wr, bus.out_ram_data);
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus.out_ram_addr, bus.out_ram_wr, bus.out_ram_data, bus.out_lsb_ce} !== {32'h101, 1'b1, 8'hBE, 1'b0}) begin
      n_fail++;
      $display("FAIL store_w1: got %h %b %h ce=%b, need 101 1 be 0", bus.out_ram_addr, bus.out_ram_wr,
               bus.out_ram_data, bus.out_lsb_ce);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.out_ram_wr !== 1'b0 || bus.out_lsb_ce !== 1'b1) begin
      n_fail++;
      $display("FAIL store_done: got wr=%b ce=%b, need 0 1", bus.out_ram_wr, bus.out_lsb_ce);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.out_lsb_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL store_ack_width: got %b, need 0", bus.out_lsb_ce);
    end
    n_chk++;
    if ({mem[10'h102], mem[10'h101], mem[10'h100]} !== 24'h55BEEF) begin
      n_fail++;
      $display("FAIL store_ram: got %h%h%h, need 55beef", mem[10'h102], mem[10'h101], mem[10'h100]);
    end
  endtask
  task automatic test_load;
    req_lsb(1'b0, 32'h100, SIZE_B, 32'h0);
    @(posedge clk); #1;
    n_chk++;
    if (bus.out_lsb_ce !== 1'b0) begin
      n_fail++;
      $display("FAIL load_early_ack: got %b, need 0", bus.out_lsb_ce);
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.out_lsb_ce !== 1'b1 || bus.out_lsb_data !== 32'h000000EF) begin
      n_fail++;
      $display("FAIL load_byte: got ce=%b data=%h, need 1 000000ef", bus.out_lsb_ce, bus.out_lsb_data);
    end
  endtask
  task automatic test_back_to_back;
    int l_at, f_at, l_n, f_n;
    logic [31:0] l_d, f_d;
    l_at = 0; f_at = 0; l_n = 0; f_n = 0; l_d = '0; f_d = '0;
    poke4(10'h010, 32'h12345678);
    poke4(10'h040, 32'hD4C3B2A1);
    bus.in_fetcher_ce = 1'b1;
    bus.in_fetcher_pc = 32'h10;
    req_lsb(1'b0, 32'h40, SIZE_W, 32'h0);
    bus.in_fetcher_ce = 1'b0;
    n_chk++;
    if (bus.out_ram_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL arb_first_addr: got %h, need 40", bus.out_ram_addr);
    end
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (bus.out_lsb_ce) begin l_n++; l_at = c; l_d = bus.out_lsb_data; end
      if (bus.out_fetcher_ce) begin f_n++; f_at = c; f_d = bus.out_fetcher_instr; end
    end
    n_chk++;
    if (l_n != 1 || l_at != 5 || l_d !== 32'hD4C3B2A1) begin
      n_fail++;
      $display("FAIL arb_load: got n=%0d at=%0d data=%h, need 1 5 d4c3b2a1", l_n, l_at, l_d);
    end
    n_chk++;
    if (f_n != 1 || f_at != 11 || f_d !== 32'h12345678) begin
      n_fail++;
      $display("FAIL arb_fetch: got n=%0d at=%0d instr=%h, need 1 11 12345678", f_n, f_at, f_d);
    end
  endtask
  task automatic test_misbranch;
    int f_at, f_n;
    logic [31:0] f_d;
    f_at = 0; f_n = 0; f_d = '0;
    poke4(10'h020, 32'hCAFEF00D);
    poke4(10'h080, 32'h44332211);
    req_fetch(32'h20);
    @(posedge clk); #1;
    bus.in_rob_misbranch = 1'b1;
    req_fetch(32'h80);
    bus.in_rob_misbranch = 1'b0;
    for (int c = 3; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        n_chk++;
        if (bus.out_ram_addr !== 32'h80) begin
          n_fail++;
          $display("FAIL misb_new_addr: got %h, need 80", bus.out_ram_addr);
        end
      end
      if (bus.out_fetcher_ce) begin
        f_n++;
        if (f_n == 1) begin f_at = c; f_d = bus.out_fetcher_instr; end
      end
    end
    n_chk++;
    if (f_n != 1 || f_at != 8 || f_d !== 32'h44332211) begin
      n_fail++;
      $display("FAIL misb_fetch: got n=%0d at=%0d instr=%h, need 1 8 44332211", f_n, f_at, f_d);
    end
  endtask
  task automatic test_store_misbranch;
    logic [31:0] sw;
    sw = 32'h0A0B0C0D;
    req_lsb(1'b1, 32'h300, SIZE_W, sw);
    bus.in_rob_misbranch = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k == 2) bus.in_rob_misbranch = 1'b0;
      if (k > 0) begin @(posedge clk); #1; end
      n_chk++;
      if (k < 4 && {bus.out_ram_addr, bus.out_ram_wr, bus.out_ram_data, bus.out_lsb_ce} !==
                   {32'(32'h300 + k), 1'b1, sw[8*k +: 8], 1'b0}) begin
        n_fail++;
        $display("FAIL smisb_w%0d: got %h %b %h ce=%b, need %h 1 %h 0", k, bus.out_ram_addr, bus.out_ram_wr,
                 bus.out_ram_data, bus.out_lsb_ce, 32'h300 + k, sw[8*k +: 8]);
      end
      if (k == 4 && (bus.out_ram_wr !== 1'b0 || bus.out_lsb_ce !== 1'b1)) begin
        n_fail++;
        $display("FAIL smisb_done: got wr=%b ce=%b, need 0 1", bus.out_ram_wr, bus.out_lsb_ce);
      end
    end
    n_chk++;
    if ({mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]} !== sw) begin
      n_fail++;
      $display("FAIL smisb_ram: got %h%h%h%h, need %h", mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300], sw);
    end
  endtask
  task automatic test_rdy;
    int f_at;
    f_at = 0;
    req_fetch(32'h4);
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rdy = 1'b1;
    for (int c = 5; c <= 12 && f_at == 0; c++) begin
      @(posedge clk); #1;
      if (bus.out_fetcher_ce) f_at = c;
    end
    n_chk++;
    if (f_at != 8 || bus.out_fetcher_instr !== 32'h00100513) begin
      n_fail++;
      $display("FAIL rdy_stall: got at=%0d instr=%h, need 8 00100513", f_at, bus.out_fetcher_instr);
    end
  endtask
  task automatic test_rst_mid;
    int f_n;
    f_n = 0;
    req_fetch(32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if ({bus.out_fetcher_ce, bus.out_fetcher_instr, bus.out_lsb_ce, bus.out_lsb_data,
         bus.out_ram_data, bus.out_ram_addr, bus.out_ram_wr} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got fce=%b instr=%h lce=%b raddr=%h rwr=%b, need all 0",
               bus.out_fetcher_ce, bus.out_fetcher_instr, bus.out_lsb_ce, bus.out_ram_addr, bus.out_ram_wr);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_fetcher_ce) f_n++;
    end
    n_chk++;
    if (f_n != 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_ack: got %0d acks, need 0", f_n);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_load();
    test_back_to_back();
    test_misbranch();
    test_store_misbranch();
    test_rdy();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
